seven_seg_scan_ctrl: RTL and testbench

Time-multiplexes one shared BCD-to-seven-segment decoder across N_DIGITS common-anode digits on the calculator display.
- Holds a shadow copy and an active copy of the packed BCD digit vector.
- Sequences the digit index and drives the decoder input.
- Gates the decoder output onto the segment bus, with anti-ghosting blanking, leading-zero suppression and frame-synchronous updates.
- Sits between the calculator result/formatting logic and the board display pins.

---
 rtl/seven_seg_scan_ctrl.sv | 102 ++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Scans one shared BCD-to-7-segment decoder across N_DIGITS common-anode digits.
// A shadow register is committed to the displayed copy only at frame start.
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  lz_suppress,
  output logic [3:0]            bcd_out,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  update_pending,
  output logic                  frame_tick
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(N_DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_cnt;
  logic [4*N_DIGITS-1:0] r_active, r_shadow;
  logic                  r_pend, r_tick;

  logic [3:0]            w_dig [N_DIGITS];
  logic [N_DIGITS:0]     w_hi_zero;
  logic                  w_slot_end, w_frame_start, w_blank, w_lit;
  logic [3:0]            w_bcd;

  // w_hi_zero[i]: digits N_DIGITS-1 down to i of the active copy are all zero
  assign w_hi_zero[N_DIGITS] = 1'b1;
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    assign w_dig[g]     = r_active[4*g +: 4];
    assign w_hi_zero[g] = w_hi_zero[g+1] && (w_dig[g] == 4'd0);
  end

  assign w_bcd         = w_dig[r_idx];
  assign w_slot_end    = (r_state == SHOW) && (r_cnt == CW'(PRESCALE-1));
  assign w_frame_start = enable && ((r_state == IDLE) ||
                         (w_slot_end && (r_idx == IW'(N_DIGITS-1))));
  assign w_blank       = lz_suppress && (r_idx != '0) && w_hi_zero[r_idx];
  assign w_lit         = enable && (r_state == SHOW) && !w_blank;

  assign bcd_out        = w_bcd;
  assign an             = w_lit ? ~(N_DIGITS'(1) << r_idx) : '1;
  assign seg            = !w_lit ? 7'h7F : (w_bcd > 4'd9) ? 7'b0111111 : seg_in;
  assign update_pending = r_pend;
  assign frame_tick     = r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_active <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= w_frame_start;
      if (w_frame_start && r_pend) r_active <= r_shadow;
      // a load on the apply edge keeps the new shadow pending for the next frame
      r_pend <= load || (r_pend && !w_frame_start);
      if (load) r_shadow <= digits_in;

      if (!enable) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= BLANK;
            r_idx   <= '0;
            r_cnt   <= '0;
          end
          BLANK: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(BLANK_CYCLES-1)) r_state <= SHOW;
          end
          SHOW: begin
            if (w_slot_end) begin
              r_cnt   <= '0;
              r_state <= BLANK;
              r_idx   <= (r_idx == IW'(N_DIGITS-1)) ? '0 : r_idx + IW'(1);
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: per-frame vector table plus
// hand-written sequences for pending/load races, enable drop and reset.
module tb_seven_seg_scan_ctrl;
  localparam int N = 4, P = 8, B = 2;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, load = 1'b0, lz = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  bcd_out;
  logic [6:0]  seg_in, seg;
  logic [3:0]  an;
  logic        pend, tick;
  int tests = 0, fails = 0;

  seven_seg_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits),
    .lz_suppress(lz), .bcd_out(bcd_out), .seg_in(seg_in), .seg(seg), .an(an),
    .update_pending(pend), .frame_tick(tick));

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h40; 4'd1: dec = 7'h79; 4'd2: dec = 7'h24; 4'd3: dec = 7'h30;
      4'd4: dec = 7'h19; 4'd5: dec = 7'h12; 4'd6: dec = 7'h02; 4'd7: dec = 7'h78;
      4'd8: dec = 7'h00; 4'd9: dec = 7'h10; default: dec = 7'h00;
    endcase
  endfunction
  assign seg_in = dec(bcd_out);

  always @(negedge clk)
    if (rst_n && $countones(~an) > 1) begin
      fails++;
      $display("FAIL one_hot_an: an=%b", an);
    end

  typedef struct {
    logic [15:0] digits; logic lz; int cyc;
    logic [3:0] an; logic [3:0] bcd; logic [6:0] seg; logic tick;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic [15:0] d, logic l, int c, logic [3:0] a,
                              logic [3:0] b, logic [6:0] s, logic t);
    vec_t v;
    v.digits = d; v.lz = l; v.cyc = c; v.an = a; v.bcd = b; v.seg = s; v.tick = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [15:0] d);
    load = 1'b1; digits = d;
    step();
    load = 1'b0;
  endtask

  // Stops at the first cycle of a frame whose pending data has been applied
  task automatic wait_tick();
    int n;
    for (n = 0; n < 100; n++) begin
      if (tick === 1'b1 && pend === 1'b0) break;
      step();
    end
    if (n == 100) chk("wait_frame_tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cur;
    vt.push_back(mk(16'h1234, 0, 0,  4'hF, 4, 7'h7F, 1));
    vt.push_back(mk(16'h1234, 0, 1,  4'hF, 4, 7'h7F, 0));
    vt.push_back(mk(16'h1234, 0, 2,  4'hE, 4, 7'h19, 0));
    vt.push_back(mk(16'h1234, 0, 7,  4'hE, 4, 7'h19, 0));
    vt.push_back(mk(16'h1234, 0, 8,  4'hF, 3, 7'h7F, 0));
    vt.push_back(mk(16'h1234, 0, 10, 4'hD, 3, 7'h30, 0));
    vt.push_back(mk(16'h1234, 0, 18, 4'hB, 2, 7'h24, 0));
    vt.push_back(mk(16'h1234, 0, 26, 4'h7, 1, 7'h79, 0));
    vt.push_back(mk(16'h1234, 0, 31, 4'h7, 1, 7'h79, 0));
    vt.push_back(mk(16'h1234, 0, 32, 4'hF, 4, 7'h7F, 1));
    vt.push_back(mk(16'h0042, 1, 0,  4'hF, 2, 7'h7F, 1));
    vt.push_back(mk(16'h0042, 1, 2,  4'hE, 2, 7'h24, 0));
    vt.push_back(mk(16'h0042, 1, 10, 4'hD, 4, 7'h19, 0));
    vt.push_back(mk(16'h0042, 1, 18, 4'hF, 0, 7'h7F, 0));
    vt.push_back(mk(16'h0042, 1, 26, 4'hF, 0, 7'h7F, 0));
    vt.push_back(mk(16'h0042, 1, 31, 4'hF, 0, 7'h7F, 0));
    vt.push_back(mk(16'h0000, 1, 0,  4'hF, 0, 7'h7F, 1));
    vt.push_back(mk(16'h0000, 1, 2,  4'hE, 0, 7'h40, 0));
    vt.push_back(mk(16'h0000, 1, 10, 4'hF, 0, 7'h7F, 0));
    vt.push_back(mk(16'h0000, 1, 18, 4'hF, 0, 7'h7F, 0));
    vt.push_back(mk(16'h0000, 1, 26, 4'hF, 0, 7'h7F, 0));
    vt.push_back(mk(16'h00A7, 0, 0,  4'hF, 7, 7'h7F, 1));
    vt.push_back(mk(16'h00A7, 0, 2,  4'hE, 7, 7'h78, 0));
    vt.push_back(mk(16'h00A7, 0, 10, 4'hD, 4'hA, 7'h3F, 0));
    vt.push_back(mk(16'h00A7, 0, 18, 4'hB, 0, 7'h40, 0));

    #12;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_pend", pend, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    cur = 0;
    foreach (vt[i]) begin
      if (vt[i].cyc == 0) begin
        lz = vt[i].lz;
        do_load(vt[i].digits);
        enable = 1'b1;
        wait_tick();
        cur = 0;
      end else begin
        while (cur < vt[i].cyc) begin step(); cur++; end
      end
      chk($sformatf("v%0d_an", i),   an,      vt[i].an);
      chk($sformatf("v%0d_bcd", i),  bcd_out, vt[i].bcd);
      chk($sformatf("v%0d_seg", i),  seg,     vt[i].seg);
      chk($sformatf("v%0d_tick", i), tick,    vt[i].tick);
    end

    // Mid-frame load waits for the frame boundary
    lz = 1'b0;
    do_load(16'h1234);
    wait_tick();
    repeat (10) step();
    do_load(16'h5678);
    chk("midload_pend", pend, 1);
    repeat (7) step();
    chk("midload_old_bcd", bcd_out, 2);
    chk("midload_old_an", an, 4'hB);
    wait_tick();
    chk("midload_new_bcd", bcd_out, 8);
    chk("midload_pend_clr", pend, 0);

    // Last load wins; load on the apply edge keeps pending set
    do_load(16'h1111);
    do_load(16'h2222);
    wait_tick();
    chk("lastwins_bcd", bcd_out, 2);
    repeat (5) step();
    do_load(16'h4444);
    repeat (25) step();
    do_load(16'h3333);
    chk("coinc_tick", tick, 1);
    chk("coinc_bcd", bcd_out, 4);
    chk("coinc_pend", pend, 1);
    wait_tick();
    chk("coinc_next_bcd", bcd_out, 3);

    // Enable drop during digit-2 SHOW, then restart
    do_load(16'h1234);
    wait_tick();
    repeat (20) step();
    chk("en_show_an", an, 4'hB);
    enable = 1'b0; #1;
    chk("en_off_an", an, 4'hF);
    chk("en_off_seg", seg, 7'h7F);
    step();
    enable = 1'b1;
    step();
    chk("en_restart_tick", tick, 1);
    chk("en_restart_an", an, 4'hF);
    chk("en_restart_bcd", bcd_out, 4);
    repeat (2) step();
    chk("en_restart_show", an, 4'hE);

    // Asynchronous reset mid-SHOW with a pending load
    do_load(16'h9999);
    rst_n = 1'b0; #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_bcd", bcd_out, 0);
    chk("arst_pend", pend, 0);
    chk("arst_tick", tick, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_tick", tick, 1);
    repeat (2) step();
    chk("post_rst_an", an, 4'hE);
    chk("post_rst_bcd", bcd_out, 0);
    chk("post_rst_seg", seg, 7'h40);
    chk("post_rst_pend", pend, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
